// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan stage.
// Contents:
//   NIBBLE_W            width of one hex digit
//   MAX_DIGITS          largest digit count the scanner supports
//   DEFAULT_NUM_DIGITS  default number of scanned digits
//   DEFAULT_REFRESH_DIV default clk cycles each digit is held
//   nibble_t            one hex digit
//   lz_mask()           per-digit leading-zero blank vector

package seven_seg_pkg;

  localparam int NIBBLE_W            = 4;
  localparam int MAX_DIGITS          = 8;
  localparam int DEFAULT_NUM_DIGITS  = 4;
  localparam int DEFAULT_REFRESH_DIV = 50000;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Returns a vector with bit k set when digit k must be blanked.
  // Walks from the most significant digit down, so a digit is blanked
  // only while every digit above it (and itself) is zero.
  // Digit 0 is never blanked so a zero value still shows a single "0".
  // Nibbles at or above num_digits are ignored.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [NIBBLE_W*MAX_DIGITS-1:0] value,
    input int                             num_digits,
    input logic                           lz
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      if (k < num_digits) begin
        all_zero = all_zero & (value[k*NIBBLE_W +: NIBBLE_W] == '0);
        mask[k]  = lz & all_zero & (k != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_refresh_tick_gen.sv
// Refresh prescaler for the seven-segment scanner.
// Counts 0..DIV-1 and wraps; tick is high on the last count, so it
// fires exactly once every DIV clk cycles.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high; clears the count
//   tick   out  1 while the count equals DIV-1

module refresh_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: wrap to zero after the last count.
  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan stage feeding a 4-bit hex-to-7-segment decoder.
// Holds a double-buffered multi-digit hex value and cycles through its
// digits, driving one nibble and one anode enable at a time. A loaded
// value waits in a pending buffer and is only shown from the next frame
// boundary on, so a display update never tears.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   load         in   1-cycle strobe; capture value_in into pending buffer
//   value_in     in   hex value, nibble k = value_in[4k+3:4k], k=0 rightmost
//   lz_blank     in   1: suppress leading zeros (sampled live)
//   digit_out    out  nibble for the decoder input
//   an_out       out  one-hot digit enable, polarity set by ANODE_ACTIVE_LOW
//   frame_start  out  1-cycle pulse when digit 0 appears on the outputs
//   pending      out  1 while a loaded value is not yet shown

module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV      = DEFAULT_REFRESH_DIV,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  input  logic                           lz_blank,
  output logic [NIBBLE_W-1:0]            digit_out,
  output logic [NUM_DIGITS-1:0]          an_out,
  output logic                           frame_start,
  output logic                           pending
);

  localparam int                   VAL_W    = NIBBLE_W * NUM_DIGITS;
  localparam int                   IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

  logic                          tick;
  logic                          boundary;

  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [VAL_W-1:0]              shadow_q, shadow_d;
  logic [VAL_W-1:0]              pend_buf_q, pend_buf_d;
  logic                          pending_q, pending_d;
  logic                          frame_begin_q, frame_begin_d;
  nibble_t                       digit_out_q, digit_out_d;
  logic [NUM_DIGITS-1:0]         an_out_q, an_out_d;
  logic                          frame_start_q, frame_start_d;

  logic [NIBBLE_W*MAX_DIGITS-1:0] shadow_ext;
  logic [MAX_DIGITS-1:0]          blank_vec;
  logic [MAX_DIGITS-1:0]          sel_onehot;
  nibble_t                        sel_nibble;
  logic                           sel_blank;

  refresh_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_refresh_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Scan index and double buffer. At the frame boundary the pending
  // value moves into the shadow; a load in the same cycle still lands in
  // the buffer, so it is held over for the following frame.
  always_comb begin
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    pend_buf_d    = pend_buf_q;
    pending_d     = pending_q;
    boundary      = tick && (idx_q == LAST_IDX);

    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    if (boundary && pending_q) begin
      shadow_d  = pend_buf_q;
      pending_d = 1'b0;
    end

    if (load) begin
      pend_buf_d = value_in;
      pending_d  = 1'b1;
    end

    // The boundary is remembered for one cycle so frame_start lines up
    // with digit 0 reaching the registered outputs.
    frame_begin_d = boundary;
  end

  // Output stage: select the current digit's nibble and anode, and blank
  // leading zeros. The shadow is widened to the package's maximum width
  // so the shared lz_mask helper can be reused unchanged.
  always_comb begin
    shadow_ext             = '0;
    shadow_ext[VAL_W-1:0]  = shadow_q;
    blank_vec              = lz_mask(shadow_ext, NUM_DIGITS, lz_blank);
    sel_onehot             = '0;
    sel_nibble             = '0;

    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < NUM_DIGITS) begin
        if (idx_q == IDX_W'(k)) begin
          sel_onehot[k] = 1'b1;
          sel_nibble    = shadow_ext[k*NIBBLE_W +: NIBBLE_W];
        end
      end
    end

    sel_blank   = |(blank_vec & sel_onehot);
    digit_out_d = sel_nibble;

    if (sel_blank) begin
      an_out_d = AN_OFF;
    end else if (ANODE_ACTIVE_LOW != 0) begin
      an_out_d = ~sel_onehot[NUM_DIGITS-1:0];
    end else begin
      an_out_d = sel_onehot[NUM_DIGITS-1:0];
    end

    frame_start_d = frame_begin_q;
  end

  // frame_begin resets to 1: the scan restarts at digit 0 after reset,
  // which counts as the start of a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      shadow_q      <= '0;
      pend_buf_q    <= '0;
      pending_q     <= 1'b0;
      frame_begin_q <= 1'b1;
      digit_out_q   <= '0;
      an_out_q      <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      pend_buf_q    <= pend_buf_d;
      pending_q     <= pending_d;
      frame_begin_q <= frame_begin_d;
      digit_out_q   <= digit_out_d;
      an_out_q      <= an_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign digit_out   = digit_out_q;
  assign an_out      = an_out_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule
